// File: rtl/regfile_sweeper.sv
// Debug/bring-up initiator for the 3-port register file: DUMP streams every register over a
// valid/ready port, CLEAR writes CLEAR_VAL into registers 1..NREGS-1 on back-to-back cycles.
module regfile_sweeper #(
  parameter int unsigned          ADDR_W    = 5,
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          NREGS     = 32,
  parameter logic [DATA_W-1:0]    CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_CLEAR,
    S_DONE
  } state_t;

  // One spare bit so that NREGS = 2**ADDR_W never wraps the sweep index back to 0.
  localparam int unsigned     LAST_I = NREGS - 1;
  localparam logic [ADDR_W:0] LAST   = LAST_I[ADDR_W:0];

  state_t            r_state;
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   w_idx_inc;

  assign w_idx_inc = r_idx + {{ADDR_W{1'b0}}, 1'b1};

  // NOTE: the async reset clears rf_we the instant reset_n falls, so the register file can
  // never see a write on the first clock edge after reset is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rf_ra     <= '0;
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      rf_wd     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      // NOTE: every state update here is non-blocking so all registered outputs change
      // together on the edge and no ordering between statements leaks into the logic.
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (mode) begin
              r_state <= S_CLEAR;
              r_idx   <= {{ADDR_W{1'b0}}, 1'b1};
              rf_we   <= 1'b1;
              rf_wa   <= {{(ADDR_W-1){1'b0}}, 1'b1};
              rf_wd   <= CLEAR_VAL;
            end else begin
              r_state <= S_DUMP_RD;
              r_idx   <= '0;
              rf_ra   <= '0;
            end
          end
        end

        S_DUMP_RD: begin
          out_data  <= rf_rd;
          out_addr  <= r_idx[ADDR_W-1:0];
          out_valid <= 1'b1;
          r_state   <= S_DUMP_OUT;
        end

        S_DUMP_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (r_idx == LAST) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              rf_ra   <= '0;
            end else begin
              r_idx   <= w_idx_inc;
              rf_ra   <= w_idx_inc[ADDR_W-1:0];
              r_state <= S_DUMP_RD;
            end
          end
        end

        // rf_we/rf_wa already present the write for r_idx during this cycle.
        S_CLEAR: begin
          if (r_idx == LAST) begin
            rf_we   <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_idx <= w_idx_inc;
            rf_wa <= w_idx_inc[ADDR_W-1:0];
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          rf_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule
